// File: rtl/beep_pattern_ctrl.sv
// Beep pattern controller: gates the tone divider output into N timed beeps
// separated by silent gaps, under a start/busy/done handshake with abort.
module beep_pattern_ctrl #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DUR_W    = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  input  logic             start,
  input  logic             stop,
  input  logic [DUR_W-1:0] on_ms,
  input  logic [DUR_W-1:0] off_ms,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             fm_out
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  state_e           state;
  state_e           state_d;
  logic [PRE_W-1:0] presc;
  logic [DUR_W-1:0] ms_cnt;
  logic [DUR_W-1:0] on_lat;
  logic [DUR_W-1:0] off_lat;
  logic [DUR_W-1:0] dur_cur;
  logic [CNT_W-1:0] beeps_left;
  logic             ms_tick;
  logic             phase_end;
  logic             start_ok;
  logic             last_beep;
  logic             busy_d;
  logic             done_d;
  logic             fm_d;

  // A phase ends on the tick that completes its last millisecond.
  assign ms_tick   = (presc == PRE_LAST);
  assign dur_cur   = (state == S_OFF) ? off_lat : on_lat;
  assign phase_end = (state != S_IDLE) && ms_tick && (ms_cnt == dur_cur - DUR_W'(1));
  assign start_ok  = start && (count != '0) && (on_ms != '0);
  assign last_beep = (beeps_left == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; stop overrides everything, including a same-cycle start.
  always_comb begin
    state_d = state;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state_d = S_ON;
          end
        end
        S_ON: begin
          if (phase_end) begin
            if (last_beep) begin
              state_d = S_IDLE;
            end else if (off_lat == '0) begin
              state_d = S_ON;
            end else begin
              state_d = S_OFF;
            end
          end
        end
        S_OFF: begin
          if (phase_end) begin
            state_d = S_ON;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output next-values; done covers both normal completion and a rejected start.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    fm_d   = 1'b1;
    if (!stop) begin
      if (state == S_IDLE && start && !start_ok) begin
        done_d = 1'b1;
      end
      if (state == S_ON && phase_end && last_beep) begin
        done_d = 1'b1;
      end
      if (state == S_ON) begin
        fm_d = tone_in;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      fm_out <= 1'b1;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      fm_out <= fm_d;
    end
  end

  // Prescaler, per-phase ms counter, beep counter and latched parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      ms_cnt     <= '0;
      beeps_left <= '0;
      on_lat     <= '0;
      off_lat    <= '0;
    end else if (stop) begin
      presc      <= '0;
      ms_cnt     <= '0;
      beeps_left <= '0;
    end else if (state == S_IDLE) begin
      presc  <= '0;
      ms_cnt <= '0;
      if (start_ok) begin
        on_lat     <= on_ms;
        off_lat    <= off_ms;
        beeps_left <= count;
      end
    end else if (phase_end) begin
      presc  <= '0;
      ms_cnt <= '0;
      if (state == S_ON) begin
        beeps_left <= beeps_left - CNT_W'(1);
      end
    end else if (ms_tick) begin
      presc  <= '0;
      ms_cnt <= ms_cnt + DUR_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

endmodule

// File: tb/tb_beep_pattern_ctrl.sv
// Self-checking bench for beep_pattern_ctrl with TICK_DIV=4 and a tone that
// toggles every 2 cycles; per-cycle expectations come from a scoreboard queue.
module tb_beep_pattern_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DUR_W    = 10;
  localparam int unsigned CNT_W    = 4;

  logic             clk;
  logic             rst_n;
  logic             tone_in;
  logic             start;
  logic             stop;
  logic [DUR_W-1:0] on_ms;
  logic [DUR_W-1:0] off_ms;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             fm_out;

  beep_pattern_ctrl #(
    .TICK_DIV(TICK_DIV),
    .DUR_W   (DUR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tone_in(tone_in),
    .start  (start),
    .stop   (stop),
    .on_ms  (on_ms),
    .off_ms (off_ms),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .fm_out (fm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    cnt;
    int    on;
    int    off;
    int    stop_j;     // cycle after start at which stop is driven (0 = never)
    int    restart_j;  // cycle after start at which a second start is driven (0 = never)
    int    exp_busy;   // busy cycles
    int    exp_done;   // done pulses
  } vec_t;

  typedef struct {
    int   j;
    logic busy;
    logic done;
    logic fm;
  } exp_t;

  exp_t  sb[$];
  int    n_checks;
  int    n_fail;
  int    cyc;
  int    busy_seen;
  int    done_seen;
  string cur_name;

  function automatic logic tone_at(int c);
    return ((c >> 1) & 1) != 0;
  endfunction

  task automatic chk_int(string nm, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Advance to the next falling edge, check the scoreboard, then drive this cycle's inputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (busy) busy_seen++;
    if (done) done_seen++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({busy, done, fm_out} !== {e.busy, e.done, e.fm}) begin
        n_fail++;
        $display("FAIL %s j=%0d busy/done/fm_out: got %b%b%b, required %b%b%b",
                 cur_name, e.j, busy, done, fm_out, e.busy, e.done, e.fm);
      end
    end
    tone_in = tone_at(cyc);
    start   = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic push_idle(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.j = i; e.busy = 1'b0; e.done = 1'b0; e.fm = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   ph[$];
    int   eff[$];
    int   n0;
    int   t_len;
    int   len;
    exp_t e;
    cur_name = v.name;
    step();
    n0 = cyc;
    busy_seen = 0;
    done_seen = 0;
    start  = 1'b1;
    count  = CNT_W'(v.cnt);
    on_ms  = DUR_W'(v.on);
    off_ms = DUR_W'(v.off);
    // Expected phase per cycle after start: 0 idle, 1 ON, 2 OFF.
    ph.push_back(0);
    if (v.cnt != 0 && v.on != 0) begin
      for (int b = 0; b < v.cnt; b++) begin
        for (int i = 0; i < v.on * int'(TICK_DIV); i++) ph.push_back(1);
        if (b < v.cnt - 1)
          for (int i = 0; i < v.off * int'(TICK_DIV); i++) ph.push_back(2);
      end
    end
    t_len = ph.size() - 1;
    len = (v.stop_j != 0) ? v.stop_j + 2 : t_len + 2;
    for (int j = 0; j <= len; j++) begin
      if ((v.stop_j != 0 && j > v.stop_j) || j > t_len) eff.push_back(0);
      else eff.push_back(ph[j]);
    end
    for (int j = 1; j <= len; j++) begin
      e.j    = j;
      e.busy = (eff[j] != 0);
      e.done = (v.stop_j == 0) && (j == t_len + 1);
      e.fm   = (j >= 2 && eff[j-1] == 1 && !(v.stop_j != 0 && j - 1 == v.stop_j))
               ? tone_at(n0 + j - 1) : 1'b1;
      sb.push_back(e);
    end
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == 1) begin
        count  = CNT_W'($urandom);
        on_ms  = DUR_W'($urandom);
        off_ms = DUR_W'($urandom);
      end
      if (k == v.restart_j) begin
        start = 1'b1; count = CNT_W'(5); on_ms = DUR_W'(7); off_ms = DUR_W'(3);
      end
      if (k == v.stop_j) stop = 1'b1;
    end
    chk_int({v.name, " busy cycles"}, busy_seen, v.exp_busy);
    chk_int({v.name, " done pulses"}, done_seen, v.exp_done);
  endtask

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    tone_in  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    on_ms    = '0;
    off_ms   = '0;
    count    = '0;

    vecs[0] = '{"c2_on3_off2",    2,    3, 2, 0, 0,   32, 1};
    vecs[1] = '{"c3_on1_off0",    3,    1, 0, 0, 0,   12, 1};
    vecs[2] = '{"c0_reject",      0,    3, 1, 0, 0,    0, 1};
    vecs[3] = '{"on0_reject",     2,    0, 1, 0, 0,    0, 1};
    vecs[4] = '{"restart_ignored",1,    2, 5, 0, 5,    8, 1};
    vecs[5] = '{"stop_in_off",    2,    1, 2, 6, 0,    6, 0};
    vecs[6] = '{"fresh_after",    2,    2, 1, 0, 0,   20, 1};
    vecs[7] = '{"c15_on1_off1",  15,    1, 1, 0, 0,  116, 1};
    vecs[8] = '{"c1_on1023",      1, 1023, 0, 0, 0, 4092, 1};

    cur_name = "reset";
    push_idle(3);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    push_idle(2);
    for (int i = 0; i < 2; i++) step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // stop and start in the same IDLE cycle: stop wins, no busy and no done
    cur_name = "stop_and_start";
    step();
    start = 1'b1; stop = 1'b1; count = CNT_W'(2); on_ms = DUR_W'(1); off_ms = DUR_W'(1);
    push_idle(3);
    for (int i = 0; i < 3; i++) step();

    // asynchronous reset in the middle of an ON phase
    cur_name = "reset_mid_on";
    step();
    start = 1'b1; count = CNT_W'(2); on_ms = DUR_W'(3); off_ms = DUR_W'(1);
    for (int i = 0; i < 5; i++) step();
    chk_int("reset_mid_on busy before reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_int("reset_mid_on busy", int'(busy), 0);
    chk_int("reset_mid_on done", int'(done), 0);
    chk_int("reset_mid_on fm_out", int'(fm_out), 1);
    push_idle(5);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beep_pattern_ctrl.md
Name: beep_pattern_ctrl

Overview:
- Downstream stage of the tone divider.
- Consumes the divider's square wave and gates it into timed beep patterns: N beeps, each ON for on_ms milliseconds, separated by OFF gaps of off_ms milliseconds.
- Drives the beeper gate: output low = sounding edge, high = silent.
- Controlled by a start/busy/done handshake from the system control FSM.

Parameters:
- TICK_DIV, 50000, clk cycles per millisecond tick (50 MHz clk).
- DUR_W, 10, width of on_ms/off_ms (0..1023 ms).
- CNT_W, 4, width of beep count (0..15).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tone_in  in  1  square wave from tone divider, synchronous to clk.
- start  in  1  1-cycle request; sampled only in IDLE.
- stop  in  1  synchronous abort, level.
- on_ms  in  DUR_W  beep ON length in ms; latched at start.
- off_ms  in  DUR_W  gap length in ms; latched at start.
- count  in  CNT_W  number of beeps; latched at start.
- busy  out  1  high while a pattern is in progress (state != IDLE).
- done  out  1  1-cycle pulse on normal completion.
- fm_out  out  1  beeper gate.

Behaviour:
Reset:
- state=IDLE; busy=0, done=0, fm_out=1.
- Prescaler, ms counter and beep counter all 0.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps. ms_tick fires when prescaler = TICK_DIV-1.
- Cleared on every phase entry, so every phase lasts exactly ms*TICK_DIV clk cycles.

States: IDLE, ON, OFF.

IDLE:
- start=1 with count!=0 and on_ms!=0: latch on_ms, off_ms, count; beeps_left=count; go to ON next cycle.
- start=1 with count=0 or on_ms=0: stay in IDLE; done=1 on the next cycle; busy never asserts.

ON:
- Lasts on_ms ms. On the final tick, beeps_left decrements.
- If the result is 0: go to IDLE with done=1 for exactly one cycle. There is no trailing OFF gap.
- Otherwise go to OFF, or go directly to ON again if the latched off_ms=0.

OFF:
- Lasts off_ms ms, then returns to ON.

Outputs:
- fm_out is registered: fm_out <= (state==ON) ? tone_in : 1.
- It therefore follows tone_in with 1 cycle latency and returns high 1 cycle after ON exits.
- busy is registered and equals (next state != IDLE), so it rises in the first ON cycle and falls in the first IDLE cycle.
- done is coincident with busy falling.

Start handling:
- start while busy is ignored; the latched parameters are unchanged.
- Input changes during a pattern have no effect.

Stop:
- stop=1 in any state: next state is IDLE, fm_out=1 next cycle, and all counters clear.
- done is NOT pulsed on abort.
- stop has priority over start in the same cycle.

Reset mid-pattern: immediate return to reset values, with no done pulse.

Widths and wrap:
- Counters are sized DUR_W and CNT_W, so there is no overflow.
- The prescaler is sized ceil(log2(TICK_DIV)).

Test Plan:
(All scenarios run with TICK_DIV=4 and tone_in toggling every 2 cycles.)
- count=2, on_ms=3, off_ms=2, pulse start:
  - busy high for 32 cycles (ON 12, OFF 8, ON 12).
  - fm_out mirrors tone_in delayed by 1 cycle during ON, and is high during OFF.
  - done is a single pulse on cycle 33.
- count=3, on_ms=1, off_ms=0:
  - busy high for 12 continuous ON cycles with no gap.
  - done pulses once; fm_out never held high mid-pattern.
- count=0 (or on_ms=0), pulse start:
  - busy stays 0; done=1 the cycle after start; fm_out stays 1.
- start pulsed again 5 cycles into a count=1, on_ms=2 pattern:
  - ignored; pattern ends after 8 cycles; exactly one done.
- stop asserted during OFF of a count=2 pattern:
  - next cycle busy=0, fm_out=1; no done.
  - A new start afterwards runs a full fresh pattern.
- rst_n pulled low mid-ON:
  - fm_out=1, busy=0, done=0 immediately (asynchronous).
  - After release, block idles until the next start.
